// File: rtl/key_conditioner.sv
// Multi-channel push-button front end: synchronise, debounce and polarity-normalise
// each key, then generate press/release/long pulses, sticky W1C flags and a masked irq.
module key_conditioner #(
  parameter int                 N_KEYS      = 2,
  parameter int                 DEB_CYCLES  = 16,
  parameter int                 LONG_CYCLES = 256,
  parameter logic [N_KEYS-1:0]  ACTIVE_LOW  = '0
) (
  input  logic                  bb_clk_in,
  input  logic                  rst_n,
  input  logic [N_KEYS-1:0]     key_raw,
  output logic [N_KEYS-1:0]     key_level,
  output logic [N_KEYS-1:0]     key_press,
  output logic [N_KEYS-1:0]     key_release,
  output logic [N_KEYS-1:0]     key_long,
  output logic [3*N_KEYS-1:0]   evt_status,
  input  logic [3*N_KEYS-1:0]   evt_clr,
  input  logic [3*N_KEYS-1:0]   irq_en,
  output logic                  irq
);

  localparam int DEB_W  = $clog2(DEB_CYCLES);
  localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);

  logic [N_KEYS-1:0] raw_p0;
  logic [N_KEYS-1:0] raw_p1;
  logic [N_KEYS-1:0] pressed_s;
  logic [N_KEYS-1:0] toggle;
  logic [N_KEYS-1:0] long_fire;
  logic [DEB_W-1:0]  cnt_deb  [N_KEYS];
  logic [HOLD_W-1:0] cnt_hold [N_KEYS];

  function automatic logic [HOLD_W-1:0] sat_inc(input logic [HOLD_W-1:0] v);
    return (v == HOLD_MAX) ? v : v + 1'b1;
  endfunction

  // Stage p0/p1: two-flop synchroniser, reset to the inactive raw level so an
  // idle key never looks pressed coming out of reset.
  always_ff @(posedge bb_clk_in or negedge rst_n) begin
    if (!rst_n) begin
      raw_p0 <= ACTIVE_LOW;
      raw_p1 <= ACTIVE_LOW;
    end else begin
      raw_p0 <= key_raw;
      raw_p1 <= raw_p0;
    end
  end

  assign pressed_s = raw_p1 ^ ACTIVE_LOW;

  always_comb begin
    toggle    = '0;
    long_fire = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      toggle[i]    = (pressed_s[i] != key_level[i]) && (cnt_deb[i] == DEB_LAST);
      // A release landing on the long-press edge wins over the long pulse.
      long_fire[i] = key_level[i] && !toggle[i] && (cnt_hold[i] == HOLD_LAST);
    end
  end

  // Debounced level, edge pulses and hold timer.
  always_ff @(posedge bb_clk_in or negedge rst_n) begin
    if (!rst_n) begin
      key_level   <= '0;
      key_press   <= '0;
      key_release <= '0;
      key_long    <= '0;
      for (int i = 0; i < N_KEYS; i++) begin
        cnt_deb[i]  <= '0;
        cnt_hold[i] <= '0;
      end
    end else begin
      key_level   <= key_level ^ toggle;
      key_press   <= toggle & ~key_level;
      key_release <= toggle & key_level;
      key_long    <= long_fire;
      for (int i = 0; i < N_KEYS; i++) begin
        if ((pressed_s[i] == key_level[i]) || toggle[i])
          cnt_deb[i] <= '0;
        else
          cnt_deb[i] <= cnt_deb[i] + 1'b1;

        if (toggle[i] && !key_level[i])
          cnt_hold[i] <= '0;
        else if (key_level[i])
          cnt_hold[i] <= sat_inc(cnt_hold[i]);
      end
    end
  end

  // Sticky flags: a pulse in the same cycle as its clear strobe keeps the flag set.
  always_ff @(posedge bb_clk_in or negedge rst_n) begin
    if (!rst_n) begin
      evt_status <= '0;
      irq        <= 1'b0;
    end else begin
      evt_status <= (evt_status & ~evt_clr) | {key_long, key_release, key_press};
      irq        <= |(evt_status & irq_en);
    end
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: directed scenarios plus randomized key activity,
// compared every cycle against a behavioural reference model.
module tb_key_conditioner;

  localparam int         N    = 2;
  localparam int         DEB  = 4;
  localparam int         LONG = 20;
  localparam logic [1:0] AL   = 2'b10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] key_raw = 2'b10;
  logic [1:0] key_level, key_press, key_release, key_long;
  logic [5:0] evt_status;
  logic [5:0] evt_clr = '0;
  logic [5:0] irq_en = '0;
  logic       irq;

  always #100 clk = ~clk;

  key_conditioner #(
    .N_KEYS(N), .DEB_CYCLES(DEB), .LONG_CYCLES(LONG), .ACTIVE_LOW(AL)
  ) dut (
    .bb_clk_in(clk), .rst_n(rst_n), .key_raw(key_raw),
    .key_level(key_level), .key_press(key_press), .key_release(key_release),
    .key_long(key_long), .evt_status(evt_status), .evt_clr(evt_clr),
    .irq_en(irq_en), .irq(irq)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: raw pin seen two edges late; a level change is accepted
  // after DEB consecutive disagreeing samples; long fires LONG edges after press.
  logic [1:0] m_s1, m_s2, m_level, m_press, m_rel, m_long;
  logic [5:0] m_evt;
  logic       m_irq;
  int         m_run [2];
  int         m_press_at [2];
  int         edge_n = 0;
  int         cyc = 0;
  int         t_press = -1, t_long = -1, t_rel = -1, n_long = 0;

  task automatic model_reset();
    m_s1 = AL; m_s2 = AL;
    m_level = '0; m_press = '0; m_rel = '0; m_long = '0;
    m_evt = '0; m_irq = 1'b0;
    for (int i = 0; i < N; i++) begin
      m_run[i] = 0;
      m_press_at[i] = -100000;
    end
  endtask

  task automatic model_edge();
    logic [1:0] ps, lv_n, pr_n, rl_n, lg_n;
    edge_n++;
    ps = m_s2 ^ AL;
    lv_n = m_level; pr_n = '0; rl_n = '0; lg_n = '0;
    for (int i = 0; i < N; i++) begin
      if (ps[i] != m_level[i]) begin
        m_run[i]++;
        if (m_run[i] == DEB) begin
          m_run[i] = 0;
          lv_n[i] = ~m_level[i];
          if (m_level[i]) rl_n[i] = 1'b1;
          else begin
            pr_n[i] = 1'b1;
            m_press_at[i] = edge_n;
          end
        end
      end else begin
        m_run[i] = 0;
      end
      if (m_level[i] && !rl_n[i] && (edge_n - m_press_at[i] == LONG)) lg_n[i] = 1'b1;
    end
    m_irq = |(m_evt & irq_en);
    m_evt = (m_evt & ~evt_clr) | {m_long, m_rel, m_press};
    m_level = lv_n; m_press = pr_n; m_rel = rl_n; m_long = lg_n;
    m_s2 = m_s1; m_s1 = key_raw;
  endtask

  task automatic tick();
    if (rst_n) model_edge();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (key_press[1])   t_press = cyc;
    if (key_release[1]) t_rel = cyc;
    if (key_long[1]) begin
      t_long = cyc;
      n_long++;
    end
    check("level",   key_level,   m_level);
    check("press",   key_press,   m_press);
    check("release", key_release, m_rel);
    check("long",    key_long,    m_long);
    check("evt",     evt_status,  m_evt);
    check("irq",     irq,         m_irq);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_level"}, key_level, 0);
    check({tag, "_press"}, key_press, 0);
    check({tag, "_rel"},   key_release, 0);
    check({tag, "_long"},  key_long, 0);
    check({tag, "_evt"},   evt_status, 0);
    check({tag, "_irq"},   irq, 0);
  endtask

  task automatic pulse_reset(input string tag);
    #30 rst_n = 1'b0;
    model_reset();
    #1 check_all_zero(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int t_raw;

  initial begin
    model_reset();
    #10 rst_n = 1'b0;
    #5 check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Idle with both keys released (ch1 is active-low).
    repeat (10) tick();
    check("idle_level", key_level, 0);
    check("idle_evt", evt_status, 0);
    check("idle_irq", irq, 0);

    // Press ch0: accepted exactly DEB+2 edges later.
    key_raw[0] = 1'b1;
    repeat (5) tick();
    check("deb_early", key_level[0], 0);
    tick();
    check("deb_level0", key_level[0], 1);
    check("deb_press0", key_press[0], 1);
    tick();
    check("press0_width", key_press[0], 0);
    check("press0_flag", evt_status[0], 1);

    // Release ch0, clear flags, then a 3-sample glitch.
    key_raw[0] = 1'b0;
    repeat (10) tick();
    evt_clr = 6'h3f;
    tick();
    evt_clr = '0;
    check("clr_all", evt_status, 0);
    key_raw[0] = 1'b1;
    repeat (3) tick();
    key_raw[0] = 1'b0;
    repeat (10) tick();
    check("glitch_level", key_level, 0);
    check("glitch_evt", evt_status, 0);

    // Long press on active-low ch1.
    n_long = 0;
    key_raw[1] = 1'b0;
    t_raw = cyc;
    repeat (30) tick();
    key_raw[1] = 1'b1;
    check("ch1_press_lat", t_press - t_raw, 6);
    check("ch1_long_lat", t_long - t_press, LONG);
    t_raw = cyc;
    repeat (10) tick();
    check("ch1_long_once", n_long, 1);
    check("ch1_rel_lat", t_rel - t_raw, 6);
    check("ch1_evt", evt_status, 6'b101010);

    // irq path and set-wins-over-clear.
    evt_clr = 6'h3f;
    tick();
    evt_clr = '0;
    irq_en = 6'b000001;
    key_raw[0] = 1'b1;
    repeat (6) tick();
    check("irq_press0", key_press[0], 1);
    evt_clr = 6'b000001;
    tick();
    evt_clr = '0;
    check("set_wins", evt_status[0], 1);
    check("irq_not_yet", irq, 0);
    tick();
    check("irq_set", irq, 1);
    repeat (2) tick();
    evt_clr = 6'b000001;
    tick();
    evt_clr = '0;
    check("lone_clr", evt_status[0], 0);
    check("irq_hold", irq, 1);
    tick();
    check("irq_drop", irq, 0);

    // Reset while ch0 is held: re-accepted as a new press after DEB+2 edges.
    repeat (3) tick();
    pulse_reset("midrst");
    repeat (5) tick();
    check("rst_repress_early", key_press[0], 0);
    tick();
    check("rst_repress", key_press[0], 1);

    // Randomized activity.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 19) == 0) key_raw[i] = ~key_raw[i];
      evt_clr = ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'h00;
      if ($urandom_range(0, 49) == 0) irq_en = 6'($urandom);
      if (n == 1500) pulse_reset("rndrst");
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
